// File: rtl/sqr_pkg.sv
// Shared definitions for the shift-add squarer: FSM encodings and counter sizing.
package sqr_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Width of the iteration counter that walks the N multiplier bits.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sqr_ctrl.sv
// Control path of the squarer: IDLE/RUN/DONE FSM, iteration counter and strobes.
module sqr_ctrl
    import sqr_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = cnt_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          last,
    output logic          load,
    output logic          step,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt
);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;

    // FSM, counter and registered Moore status flags; 2'b11 falls back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (last) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                        r_cnt   <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath strobes: load on an accepted start, step on every RUN cycle.
    always_comb begin
        load = 1'b0;
        step = 1'b0;
        if (r_state == S_IDLE) begin
            load = start;
        end else if (r_state == S_RUN) begin
            step = 1'b1;
        end else begin
            load = 1'b0;
            step = 1'b0;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign cnt  = r_cnt;

    sqr_ctrl_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .state (r_state),
        .done  (r_done)
    );

endmodule

// File: rtl/sqr_ctrl_chk.sv
// Property checker for the squarer controller: a done pulse must follow a RUN cycle.
module sqr_ctrl_chk
    import sqr_pkg::*;
(
    input logic   clk,
    input logic   rst,
    input state_t state,
    input logic   done
);

    // done may only be seen in the cycle right after the state was RUN.
    a_done_after_run: assert property (@(posedge clk) disable iff (rst)
        done |-> ($past(state) == S_RUN))
        else $error("sqr_ctrl_chk: done without preceding RUN");

endmodule

// File: rtl/sqr_shift_add.sv
// Sequential squarer: x*x by N shift-and-add iterations, result held in sq.
module sqr_shift_add
    import sqr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   x,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] sq
);

    localparam int CW = cnt_width(N);

    logic [2*N-1:0] r_acc;
    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mplr;
    logic [2*N-1:0] r_sq;
    logic [2*N-1:0] w_acc_next;
    logic [CW-1:0]  w_cnt;
    logic           w_last;
    logic           w_load;
    logic           w_step;

    sqr_ctrl #(.N(N), .CW(CW)) u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .last  (w_last),
        .load  (w_load),
        .step  (w_step),
        .busy  (busy),
        .done  (done),
        .cnt   (w_cnt)
    );

    assign w_last = (w_cnt == CW'(N - 1));

    // Conditional partial-product add; the square always fits so no carry is kept.
    always_comb begin
        w_acc_next = r_acc;
        if (r_mplr[0]) begin
            w_acc_next = r_acc + r_mcand;
        end else begin
            w_acc_next = r_acc;
        end
    end

    // Shift-add datapath and result register, loaded only on the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_sq    <= '0;
        end else if (w_load) begin
            r_acc   <= '0;
            r_mcand <= {{N{1'b0}}, x};
            r_mplr  <= x;
        end else if (w_step) begin
            r_acc   <= w_acc_next;
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
            if (w_last) begin
                r_sq <= w_acc_next;
            end
        end
    end

    assign sq = r_sq;

endmodule

// File: doc/sqr_shift_add.md
SQR_SHIFT_ADD -- requirements
Module: sqr_shift_add

Interface
REQ-001 Parameter N SHALL exist: default 8; operand width in bits (N >= 2).
REQ-002 Port clk SHALL be input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be input, 1 bit: synchronous, active-high reset.
REQ-004 Port start SHALL be input, 1 bit: request to square x; sampled only in IDLE.
REQ-005 Port x SHALL be input, N bits: unsigned operand; captured on the accepted start edge.
REQ-006 Port busy SHALL be output, 1 bit: high while state is RUN.
REQ-007 Port done SHALL be output, 1 bit: high for exactly one cycle while state is DONE.
REQ-008 Port sq SHALL be output, 2N bits: unsigned x*x; updated only on completion, held otherwise.

Function
REQ-009 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-010 IDLE with start=1 at an edge -> RUN; at that edge acc=0, mcand={N zeros, x}, mplr=x, cnt=0.
REQ-011 IDLE with start=0 -> stay in IDLE; no register changes.
REQ-012 Each RUN edge: if mplr[0]=1, acc += mcand (2N-bit add); then mcand <<= 1, mplr >>= 1, cnt += 1.
REQ-013 On the RUN edge where cnt=N-1 -> DONE; at that same edge sq is loaded with the final acc value, including that edge's add.
REQ-014 DONE -> IDLE unconditionally on the next edge; start in DONE SHALL be ignored.
REQ-015 Latency: start accepted at edge E0; done high in the cycle following edge E0+N; the next start can be accepted at edge E0+N+2.
REQ-016 start during RUN SHALL be ignored; x changes after E0 SHALL NOT affect the result.
REQ-017 No overflow SHALL be possible, since (2^N-1)^2 < 2^(2N); carry-out of the 2N-bit add is discarded and is always 0.
REQ-018 sq SHALL retain the last result through IDLE and RUN until the next DONE entry.
REQ-019 busy and done SHALL be decoded from the state register only (Moore), with no combinational path from start.

Reset
REQ-020 rst=1 at an edge SHALL force state=IDLE, acc=0, mcand=0, mplr=0, cnt=0 and sq=0, overriding every other input.
REQ-021 After reset: busy=0, done=0, sq=0.
REQ-022 rst asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; sq SHALL be 0 afterwards.

Structure
REQ-023 State encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the counter-width function SHALL live in shared package sqr_pkg.
REQ-024 The counter width SHALL be clog2(N).
REQ-025 FSM plus iteration counter SHALL be a sub-module sqr_ctrl (inputs start, last; outputs load, step, busy, done).
REQ-026 The shift-add datapath SHALL remain in the sqr_shift_add top level.
REQ-027 The unused state encoding 2'b11 SHALL recover to IDLE on the next edge.

Verification
REQ-028 N=8, x=13, start pulse at E0 -> busy high for 8 cycles; done high in the cycle after E8; sq=169.
REQ-029 x=255 -> sq=65025; x=0 -> sq=0 with done still pulsed at the same latency.
REQ-030 start held high continuously with x=3 -> results at 10-cycle spacing; sq=9 each time; done never high in two consecutive cycles.
REQ-031 After start with x=7, x driven to 200 and start pulsed during RUN -> sq=49; no extra operation is started.
REQ-032 rst asserted at E4 of a run with x=100 -> busy=0, done=0, sq=0 from the next cycle; a fresh start with x=100 -> sq=10000.
REQ-033 A random sweep over all 256 operands SHALL match a golden x*x model.
REQ-034 An assertion SHALL check that done implies the state was RUN in the previous cycle.
